// File: rtl/clk_en_pll_sequencer.sv
// ============================================================================
// Module      : clk_en_pll_sequencer
// Description : Debounced PLL-lock sequencer with fabric reset generation and
//               CHANNELS fractional clock-enable pulse generators.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clk_en_pll_sequencer #(
    parameter int CHANNELS  = 4,
    parameter int ACC_W     = 24,
    parameter int LOCK_HOLD = 1024,
    parameter int RST_HOLD  = 16
) (
    input  logic                      clkin,
    input  logic                      reset,
    input  logic                      pll_lock,
    input  logic                      sync_clr,
    input  logic [CHANNELS*ACC_W-1:0] inc,
    input  logic [CHANNELS-1:0]       ch_en,
    output logic                      locked,
    output logic                      rst_out,
    output logic [CHANNELS-1:0]       ce,
    output logic [1:0]                state
);

    localparam logic [1:0] c_st_unlocked = 2'd0;
    localparam logic [1:0] c_st_settle   = 2'd1;
    localparam logic [1:0] c_st_release  = 2'd2;
    localparam logic [1:0] c_st_run      = 2'd3;

    localparam int CNT_MAX = (LOCK_HOLD > RST_HOLD) ? LOCK_HOLD : RST_HOLD;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    logic             meta_q;
    logic             lock_s_q;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             w_run;

    // Two-flop synchroniser for the asynchronous PLL lock.
    always_ff @(posedge clkin) begin
        if (reset) begin
            meta_q   <= 1'b0;
            lock_s_q <= 1'b0;
        end else begin
            meta_q   <= pll_lock;
            lock_s_q <= meta_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!lock_s_q) begin
            state_d = c_st_unlocked;
            cnt_d   = '0;
        end else begin
            case (state_q)
                c_st_unlocked: begin
                    state_d = c_st_settle;
                    cnt_d   = '0;
                end
                c_st_settle: begin
                    if (cnt_q == CNT_W'(LOCK_HOLD - 1)) begin
                        state_d = c_st_release;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                c_st_release: begin
                    if (cnt_q == CNT_W'(RST_HOLD - 1)) begin
                        state_d = c_st_run;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = c_st_run;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q <= c_st_unlocked;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state   = state_q;
    assign locked  = (state_q == c_st_run);
    assign rst_out = (state_q != c_st_run);

    // Accumulate only while already in RUN and staying there this edge.
    assign w_run = (state_q == c_st_run) && lock_s_q;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        logic [ACC_W-1:0] acc_q;
        logic             ce_q;
        logic [ACC_W:0]   w_sum;

        assign w_sum = {1'b0, acc_q} + {1'b0, inc[k*ACC_W +: ACC_W]};

        always_ff @(posedge clkin) begin
            if (reset || !w_run || sync_clr) begin
                acc_q <= '0;
                ce_q  <= 1'b0;
            end else if (ch_en[k]) begin
                acc_q <= w_sum[ACC_W-1:0];
                ce_q  <= w_sum[ACC_W];
            end else begin
                ce_q  <= 1'b0;
            end
        end

        assign ce[k] = ce_q;
    end

endmodule

`default_nettype wire

// File: tb/tb_clk_en_pll_sequencer.sv
// ============================================================================
// Module      : tb_clk_en_pll_sequencer
// Description : Scoreboard bench for clk_en_pll_sequencer with a lock-streak
//               and integer phase-accumulator reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clk_en_pll_sequencer;

    localparam int CH     = 4;
    localparam int AW     = 24;
    localparam int LH     = 8;
    localparam int RH     = 4;
    localparam int RUN_AT = LH + RH + 1;
    localparam longint unsigned MODV = 64'd1 << AW;

    logic               clk = 1'b0;
    logic               reset;
    logic               pll_lock;
    logic               sync_clr;
    logic [CH*AW-1:0]   inc;
    logic [CH-1:0]      ch_en;
    logic               locked;
    logic               rst_out;
    logic [CH-1:0]      ce;
    logic [1:0]         state;

    clk_en_pll_sequencer #(
        .CHANNELS  (CH),
        .ACC_W     (AW),
        .LOCK_HOLD (LH),
        .RST_HOLD  (RH)
    ) dut (
        .clkin    (clk),
        .reset    (reset),
        .pll_lock (pll_lock),
        .sync_clr (sync_clr),
        .inc      (inc),
        .ch_en    (ch_en),
        .locked   (locked),
        .rst_out  (rst_out),
        .ce       (ce),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          st;
        logic [CH-1:0] ce;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Model: lock quality is the count of consecutive edges the synchronised
    // lock has been seen high; the state follows from that count alone.
    logic            m_s1 = 1'b0;
    logic            m_s2 = 1'b0;
    int              m_streak = 0;
    longint unsigned m_acc[CH];

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        exp_t            e;
        bit              prev_run;
        longint unsigned sum;
        e.ce = '0;
        if (reset) begin
            m_s1 = 1'b0;
            m_s2 = 1'b0;
            m_streak = 0;
            for (int k = 0; k < CH; k++) m_acc[k] = 0;
        end else begin
            prev_run = (m_streak >= RUN_AT);
            m_streak = m_s2 ? ((m_streak < 1000000) ? m_streak + 1 : m_streak) : 0;
            m_s2 = m_s1;
            m_s1 = pll_lock;
            if (prev_run && (m_streak >= RUN_AT) && !sync_clr) begin
                for (int k = 0; k < CH; k++) begin
                    if (ch_en[k]) begin
                        sum = m_acc[k] + longint'(inc[k*AW +: AW]);
                        e.ce[k] = (sum >= MODV);
                        m_acc[k] = sum % MODV;
                    end
                end
            end else begin
                for (int k = 0; k < CH; k++) m_acc[k] = 0;
            end
        end
        if (m_streak == 0)            e.st = 0;
        else if (m_streak <= LH)      e.st = 1;
        else if (m_streak <= LH + RH) e.st = 2;
        else                          e.st = 3;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lock(output int n);
        n = 0;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (locked === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Monitor: one expected entry per clock edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state",   longint'(state),   longint'(e.st));
                chk("locked",  longint'(locked),  longint'(e.st == 3));
                chk("rst_out", longint'(rst_out), longint'(e.st != 3));
                chk("ce",      longint'(ce),      longint'(e.ce));
            end
        end
    end

    initial begin
        int n;
        int cnt;
        int both;
        int ch;
        reset    = 1'b1;
        pll_lock = 1'b0;
        sync_clr = 1'b0;
        ch_en    = '1;
        inc      = {24'h123457, 24'h200000, 24'h555556, 24'h800000};
        repeat (3) step();

        reset    = 1'b0;
        pll_lock = 1'b1;
        wait_lock(n);
        chk("t1_lock_edges", n, 15);

        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        cnt = 0;
        repeat (9000) begin
            step();
            cnt += int'(ce[1]);
        end
        chk("t3_ce1_pulses", cnt, 3000);

        ch_en[3] = 1'b0;
        repeat (5) step();
        ch_en[3] = 1'b1;
        repeat (20) step();

        inc[0 +: AW] = 24'h200000;
        repeat (5) step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        both = 0;
        repeat (24) begin
            step();
            both += int'(ce[0] & ce[2]);
        end
        chk("t5_coincide", both, 3);

        inc[0 +: AW] = 24'h800000;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        step();
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        repeat (6) step();

        pll_lock = 1'b0;
        repeat (6) step();
        pll_lock = 1'b1;
        repeat (6) step();
        pll_lock = 1'b0;
        step();
        pll_lock = 1'b1;
        wait_lock(n);
        chk("t2_relock_edges", n, 15);

        repeat (10) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_lock(n);
        chk("t6_reset_relock", n, 15);

        repeat (3000) begin
            pll_lock = ($urandom_range(0, 399) != 0);
            sync_clr = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 19) == 0) ch_en[$urandom_range(0, CH-1)] ^= 1'b1;
            if ($urandom_range(0, 99) == 0) begin
                ch = $urandom_range(0, CH-1);
                case ($urandom_range(0, 3))
                    0:       inc[ch*AW +: AW] = '0;
                    1:       inc[ch*AW +: AW] = '1;
                    default: inc[ch*AW +: AW] = AW'($urandom);
                endcase
            end
            step();
        end

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
